// File: rtl/sa_row_loader.sv
// Row feeder for the combinational systolic Gaussian-elimination array: streams DAT_D rows
// from a synchronous row RAM, waits for the array's finish edge and reports rank and cycle count.
module sa_row_loader #(
    parameter int unsigned DAT_W   = 8,
    parameter int unsigned DAT_D   = 7,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              full_rank,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [DAT_W-1:0]  mem_q,
    output logic              sa_start,
    output logic [DAT_W-1:0]  sa_data,
    input  logic              sa_finish,
    input  logic              sa_full_rank
);

    localparam int unsigned KW  = $clog2(DAT_D + 1);
    localparam int unsigned KW1 = KW + 1;
    localparam int unsigned TW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StPrime, StStream, StWaitFin, StDone} state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [TW-1:0]       wait_q, wait_d;
    logic                fin_prev_q;
    logic                busy_q, busy_d, done_q, done_d;
    logic                full_rank_q, full_rank_d, timeout_q, timeout_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_rden_q, mem_rden_d;
    logic                sa_start_q, sa_start_d;
    logic [DAT_W-1:0]    sa_data_q, sa_data_d;
    logic [KW1-1:0]      rd_idx;
    logic                rd_en;
    logic                fin_edge;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        wait_d      = wait_q;
        full_rank_d = full_rank_q;
        timeout_d   = timeout_q;
        cycles_d    = cycles_q;
        mem_addr_d  = '0;
        mem_rden_d  = 1'b0;
        sa_start_d  = 1'b0;
        sa_data_d   = '0;
        rd_idx      = '0;
        rd_en       = 1'b0;
        fin_edge    = sa_finish & ~fin_prev_q;

        // Counter runs from the sa_start cycle (row index 1) through the finish cycle.
        if (((state_q == StStream) && (k_q != '0)) || (state_q == StWaitFin)) begin
            if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d     = StPrime;
                    full_rank_d = 1'b0;
                    timeout_d   = 1'b0;
                    cycles_d    = '0;
                    mem_rden_d  = 1'b1;
                end
            end
            StPrime: begin
                state_d = StStream;
                k_d     = '0;
                rd_idx  = KW1'(1);
                rd_en   = 1'b1;
            end
            StStream: begin
                sa_start_d = (k_q == '0);
                if (k_q < KW'(DAT_D)) sa_data_d = mem_q;
                if (k_q == KW'(DAT_D)) begin
                    state_d = StWaitFin;
                    wait_d  = '0;
                end else begin
                    k_d = k_q + KW'(1);
                    // The cycle after the last row is a drain slot with no address issued.
                    if (k_q != KW'(DAT_D - 1)) begin
                        rd_idx = {1'b0, k_q} + KW1'(2);
                        rd_en  = 1'b1;
                    end
                end
            end
            StWaitFin: begin
                if (fin_edge) begin
                    full_rank_d = sa_full_rank;
                    state_d     = StDone;
                end else if (wait_q == TW'(TIMEOUT - 2)) begin
                    timeout_d   = 1'b1;
                    full_rank_d = 1'b0;
                    state_d     = StDone;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rd_en) begin
            mem_rden_d = (rd_idx < KW1'(DAT_D));
            mem_addr_d = mem_rden_d ? ADDR_W'(rd_idx) : ADDR_W'(DAT_D - 1);
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            wait_q      <= '0;
            fin_prev_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            full_rank_q <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
            mem_addr_q  <= '0;
            mem_rden_q  <= 1'b0;
            sa_start_q  <= 1'b0;
            sa_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            fin_prev_q  <= sa_finish;
            busy_q      <= busy_d;
            done_q      <= done_d;
            full_rank_q <= full_rank_d;
            timeout_q   <= timeout_d;
            cycles_q    <= cycles_d;
            mem_addr_q  <= mem_addr_d;
            mem_rden_q  <= mem_rden_d;
            sa_start_q  <= sa_start_d;
            sa_data_q   <= sa_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign full_rank = full_rank_q;
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rden  = mem_rden_q;
    assign sa_start  = sa_start_q;
    assign sa_data   = sa_data_q;

endmodule

// File: tb/tb_sa_row_loader.sv
// Bench for sa_row_loader: cycle-offset model of a job checked every cycle, plus directed
// scenarios with literal expectations; a second instance with a 4-bit counter covers saturation.
module tb_sa_row_loader;

    localparam int D  = 7;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    logic fin = 1'b0;
    logic sfr = 1'b0;
    logic [DW-1:0] mem_q = '0;

    logic          busy, done, full_rank, timeout, mem_rden, sa_start;
    logic [15:0]   cycles;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] sa_data;

    logic          busy_s, done_s, full_rank_s, timeout_s, mem_rden_s, sa_start_s;
    logic [3:0]    cycles_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] sa_data_s;

    sa_row_loader #(.DAT_W(DW), .DAT_D(D), .ADDR_W(AW), .CNT_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done), .full_rank(full_rank),
        .timeout(timeout), .cycles(cycles), .mem_addr(mem_addr), .mem_rden(mem_rden),
        .mem_q(mem_q), .sa_start(sa_start), .sa_data(sa_data), .sa_finish(fin),
        .sa_full_rank(sfr)
    );

    sa_row_loader #(.DAT_W(DW), .DAT_D(D), .ADDR_W(AW), .CNT_W(4), .TIMEOUT(TO)) dut_s (
        .clk(clk), .rst(rst), .go(go), .busy(busy_s), .done(done_s), .full_rank(full_rank_s),
        .timeout(timeout_s), .cycles(cycles_s), .mem_addr(mem_addr_s), .mem_rden(mem_rden_s),
        .mem_q(mem_q), .sa_start(sa_start_s), .sa_data(sa_data_s), .sa_finish(fin),
        .sa_full_rank(sfr)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [D];
    always @(posedge clk) if (mem_rden) mem_q <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Job model: everything is a function of the offset t from the accepted go cycle.
    bit chk_en   = 1'b0;
    bit m_job    = 1'b0;
    bit m_ended  = 1'b0;
    bit m_fr     = 1'b0;
    bit m_to     = 1'b0;
    bit m_prev   = 1'b1;
    int m_g      = 0;
    int m_done_t = 0;
    int m_cyc    = 0;

    always @(negedge clk) begin
        int t;
        int e_addr;
        int e_data;
        if (chk_en) begin
            t      = cyc - m_g;
            e_addr = (m_job && t >= 1 && t <= D + 1) ? ((t - 1 < D - 1) ? t - 1 : D - 1) : 0;
            e_data = (m_job && t >= 3 && t <= D + 2) ? int'(ram[t-3]) : 0;
            chk("busy", int'(busy), int'(m_job));
            chk("done", int'(done), int'(m_job && m_ended && t == m_done_t));
            chk("mem_rden", int'(mem_rden), int'(m_job && t >= 1 && t <= D));
            chk("mem_addr", int'(mem_addr), e_addr);
            chk("sa_start", int'(sa_start), int'(m_job && t == 3));
            chk("sa_data", int'(sa_data), e_data);
            chk("full_rank", int'(full_rank), int'(m_fr));
            chk("timeout", int'(timeout), int'(m_to));
            chk("cycles", int'(cycles), (m_cyc > 65535) ? 65535 : m_cyc);
            chk("cycles_sat", int'(cycles_s), (m_cyc > 15) ? 15 : m_cyc);
            chk("done_sat", int'(done_s), int'(m_job && m_ended && t == m_done_t));

            if (rst) begin
                m_job = 0; m_ended = 0; m_fr = 0; m_to = 0; m_cyc = 0;
            end else if (!m_job) begin
                if (go) begin
                    m_job = 1; m_g = cyc; m_ended = 0; m_fr = 0; m_to = 0; m_cyc = 0;
                end
            end else if (m_ended && t == m_done_t) begin
                m_job = 0;
            end else begin
                if (t >= 3 && !m_ended) m_cyc++;
                if (!m_ended && t >= D + 3) begin
                    if (fin && !m_prev) begin
                        m_ended = 1; m_done_t = t + 1; m_fr = sfr;
                    end else if (t == D + 1 + TO) begin
                        m_ended = 1; m_done_t = t + 1; m_to = 1; m_fr = 0;
                    end
                end
            end
            m_prev = rst ? 1'b1 : fin;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    initial begin
        int g;
        for (int k = 0; k < D; k++) ram[k] = DW'(1 << k);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();

        // Identity matrix, finish at g+20.
        g = cyc;
        pulse_go();
        at(g + 1); @(negedge clk); chk("t1_busy", int'(busy), 1);
        at(g + 3); @(negedge clk); chk("t1_start", int'(sa_start), 1);
        chk("t1_row0", int'(sa_data), 'h01);
        at(g + 9); @(negedge clk); chk("t1_row6", int'(sa_data), 'h40);
        at(g + 20); sfr = 1'b1; fin = 1'b1; tick(); fin = 1'b0;
        @(negedge clk);
        chk("t1_done", int'(done), 1);
        chk("t1_full_rank", int'(full_rank), 1);
        chk("t1_cycles", int'(cycles), 18);
        at(g + 24);

        // Duplicate rows 2 and 5, array reports rank deficient; finish held as a level.
        ram[0] = 'h03; ram[1] = 'h05; ram[2] = 'h09; ram[3] = 'h11;
        ram[4] = 'h21; ram[5] = 'h09; ram[6] = 'h41;
        g = cyc;
        pulse_go();
        at(g + 14); sfr = 1'b0; fin = 1'b1;
        at(g + 15); @(negedge clk);
        chk("t2_done", int'(done), 1);
        chk("t2_full_rank", int'(full_rank), 0);
        chk("t2_timeout", int'(timeout), 0);
        at(g + 18); fin = 1'b0;
        at(g + 20);

        // go while busy and in DONE is dropped; go in the following idle cycle is taken.
        g = cyc;
        pulse_go();
        at(g + 5); pulse_go();
        at(g + 8); @(negedge clk); chk("t3_no_restart", int'(sa_start), 0);
        at(g + 15); sfr = 1'b1; fin = 1'b1; tick(); fin = 1'b0;
        go = 1'b1; tick(); tick(); go = 1'b0;
        g = g + 17;
        at(g + 1); @(negedge clk);
        chk("t3_fr_clear", int'(full_rank), 0);
        chk("t3_cycles_clear", int'(cycles), 0);
        at(g + 3); @(negedge clk); chk("t3_restart", int'(sa_start), 1);
        at(g + 12); sfr = 1'b1; fin = 1'b1; tick(); fin = 1'b0;
        at(g + 16);

        // Reset mid-stream, then a clean job from row 0.
        g = cyc;
        pulse_go();
        at(g + 6); rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        chk("t4_busy", int'(busy), 0);
        chk("t4_data", int'(sa_data), 0);
        tick(); tick(); tick();
        g = cyc;
        pulse_go();
        at(g + 3); @(negedge clk); chk("t4_row0", int'(sa_data), 'h03);
        at(g + 12); sfr = 1'b0; fin = 1'b1; tick(); fin = 1'b0;
        at(g + 16);

        // Finish already high before go: no edge, so the job times out.
        fin = 1'b1; sfr = 1'b1;
        tick(); tick();
        g = cyc;
        pulse_go();
        at(g + 24); @(negedge clk); chk("t5_no_done_early", int'(done), 0);
        at(g + 25); @(negedge clk);
        chk("t5_done", int'(done), 1);
        chk("t5_timeout", int'(timeout), 1);
        chk("t5_full_rank", int'(full_rank), 0);
        at(g + 27); fin = 1'b0;
        tick(); tick();

        // Finish 20 cycles after sa_start: 4-bit counter saturates.
        g = cyc;
        pulse_go();
        at(g + 22); sfr = 1'b1; fin = 1'b1; tick(); fin = 1'b0;
        @(negedge clk);
        chk("t6_done", int'(done_s), 1);
        chk("t6_cycles_sat", int'(cycles_s), 15);
        chk("t6_cycles_wide", int'(cycles), 20);
        at(g + 26);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_row_loader.md
Name: sa_row_loader

Overview:
- Upstream feeder for the combinational systolic Gaussian-elimination array (comb_SA).
- On a single `go` request it performs these steps:
  - reads DAT_D matrix rows from a synchronous-read row RAM (1-cycle read latency);
  - streams them into the array one row per cycle, with a one-cycle `sa_start` pulse aligned to row 0;
  - waits for the array's `finish`;
  - reports `full_rank` and the elimination cycle count to the controlling logic.
- Replaces the hand-written stimulus sequencing currently used around the array.

Parameters:
- DAT_W, 8, row width in bits (matches the array's DAT_W).
- DAT_D, 7, number of rows streamed per matrix.
- ADDR_W, 3, row RAM address width; must be ≥ clog2(DAT_D).
- CNT_W, 16, width of the elimination cycle counter.
- TIMEOUT, 1024, maximum cycles to wait for `sa_finish` after the last row.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- go  in  1  start request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a job ends (finish or timeout).
- full_rank  out  1  captured `sa_full_rank`; valid from `done` until the next `go`.
- timeout  out  1  set with `done` if no finish arrived; cleared on the next accepted `go`.
- cycles  out  CNT_W  cycles from `sa_start` up to and including the cycle `sa_finish` is seen; saturates at all-ones.
- mem_addr  out  ADDR_W  row RAM read address.
- mem_rden  out  1  row RAM read enable.
- mem_q  in  DAT_W  row RAM read data; valid one cycle after its address.
- sa_start  out  1  start pulse to the array, coincident with row 0.
- sa_data  out  DAT_W  row data to the array.
- sa_finish  in  1  array finish; level or pulse, rising edge used.
- sa_full_rank  in  1  array full-rank flag; valid when `sa_finish` rises.

Behaviour:
- Reset values: all outputs 0; state = IDLE; row index = 0; finish-edge history register = 1 (so a finish already high is not taken as an edge).
- States: IDLE, PRIME, STREAM, WAIT_FIN, DONE.
- All outputs are registered.
- IDLE:
  - `go` = 1 at cycle g → PRIME at g+1.
  - On entering PRIME, clear `full_rank`, `timeout` and `cycles`.
- PRIME (one cycle, g+1):
  - mem_addr = 0, mem_rden = 1.
  - → STREAM.
- STREAM, row index k = 0..DAT_D-1:
  - mem_addr = k+1 at cycle g+2+k, with mem_rden = 1 while k+1 < DAT_D.
  - sa_data = row k at cycle g+3+k (registered from mem_q).
  - sa_start = 1 only at cycle g+3.
  - The last row appears at g+2+DAT_D.
  - mem_addr never exceeds DAT_D-1; mem_rden = 0 outside PRIME/STREAM.
- WAIT_FIN:
  - sa_data = 0, sa_start = 0.
  - The `cycles` counter runs from the `sa_start` cycle, counting 1 there.
  - On a rising edge of `sa_finish`: capture `full_rank` ← `sa_full_rank`, freeze `cycles`, → DONE.
  - If TIMEOUT cycles elapse after the last row with no edge: timeout = 1, full_rank = 0, → DONE.
- Finish edge during STREAM (early finish): ignored; only edges seen in WAIT_FIN count.
- DONE (one cycle):
  - done = 1; → IDLE.
  - busy stays 1 in DONE.
  - A `go` in the DONE cycle is ignored; `go` is accepted only from the following IDLE cycle.
- `go` while busy: ignored; no queueing.
- `cycles` saturates at 2^CNT_W − 1 and never wraps.
- rst asserted in any state (including mid-STREAM):
  - next cycle all outputs = 0, state = IDLE;
  - the partial stream is abandoned with no further `sa_start`;
  - the next `go` restarts from row 0.
- DAT_D = 1: sa_start and the single row appear at g+3; → WAIT_FIN at g+4.

Test Plan:
- Reset, load identity rows 0000001…1000000 (DAT_D = 7), `go` at cycle g → busy at g+1; sa_start only at g+3; sa_data = rows 0..6 at g+3..g+9; mem_addr sequence 0..6; sa_finish at g+20 → done at g+21 with full_rank = 1, cycles = 18.
- Load a matrix with duplicate rows 2 and 5, `sa_full_rank` = 0 at finish → full_rank = 0, timeout = 0, one done pulse.
- Pulse `go` at g+5 and in the DONE cycle → no restart, no extra sa_start; `go` in the next IDLE cycle → new stream begins 3 cycles later with full_rank/timeout cleared.
- Assert rst for one cycle at g+6 (mid-STREAM) → following cycle sa_data = 0, busy = 0, done never pulses; a fresh `go` streams all 7 rows from row 0.
- Hold sa_finish = 0 with TIMEOUT = 16 → done and timeout = 1 exactly 16 cycles after the last row; sa_finish held high before `go` produces no false finish.
- Force CNT_W = 4 with finish 20 cycles after sa_start → cycles = 15 (saturated).
